// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: ALU op codes, FSM state
// encodings and the latched-operand bundle.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_SRA = 2'b00,
    OP_SRL = 2'b01,
    OP_SUB = 2'b10,
    OP_ADD = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] c;
    alu_op_e    op;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// 4-bit combinational ALU: arithmetic/logical right shift by 0..3, and
// add/sub with wrap-around.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [3:0] in_a_i,
  input  logic [3:0] in_b_i,
  input  logic [1:0] in_c_i,
  input  alu_op_e    op_i,
  output logic [3:0] ans_o
);

  // Result selection by op code
  always_comb begin
    ans_o = 4'h0;
    case (op_i)
      OP_SRA:  ans_o = 4'($signed(in_a_i) >>> in_c_i);
      OP_SRL:  ans_o = in_a_i >> in_c_i;
      OP_SUB:  ans_o = in_a_i - in_b_i;
      OP_ADD:  ans_o = in_a_i + in_b_i;
      default: ans_o = 4'h0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters; one transaction in
// flight, IDLE -> EXEC -> RESP with round-robin or fixed-priority grant.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter logic RR_INIT    = 1'b0,
  parameter int   FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req0_c,
  input  logic [1:0] req0_op,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [3:0] rsp0_ans,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req1_c,
  input  logic [1:0] req1_op,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [3:0] rsp1_ans,
  output logic       busy
);

  arb_state_e state_q;
  logic       ptr_q;
  logic       owner_q;
  alu_req_t   req_q;
  logic [3:0] result_q;

  logic       grant;
  logic       accept;
  logic       rsp_ready_sel;
  alu_req_t   sel_req;
  logic [3:0] alu_ans;

  // Tie-break: the pointer only matters when both ports are valid
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = (FIXED_PRIO != 0) ? 1'b0 : ptr_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
  end

  // Operand bundle of the granted port and response-side ready of the owner
  always_comb begin
    sel_req       = '{a: req0_a, b: req0_b, c: req0_c, op: alu_op_e'(req0_op)};
    rsp_ready_sel = owner_q ? rsp1_ready : rsp0_ready;
    if (grant) begin
      sel_req = '{a: req1_a, b: req1_b, c: req1_c, op: alu_op_e'(req1_op)};
    end else begin
      sel_req = '{a: req0_a, b: req0_b, c: req0_c, op: alu_op_e'(req0_op)};
    end
  end

  assign req0_ready = (state_q == ST_IDLE) && !grant && req0_valid;
  assign req1_ready = (state_q == ST_IDLE) &&  grant && req1_valid;
  assign accept     = req0_ready || req1_ready;

  assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
  assign rsp1_valid = (state_q == ST_RESP) &&  owner_q;
  assign rsp0_ans   = rsp0_valid ? result_q : 4'h0;
  assign rsp1_ans   = rsp1_valid ? result_q : 4'h0;
  assign busy       = (state_q != ST_IDLE);

  alu_arbiter_alu u_alu (
    .in_a_i (req_q.a),
    .in_b_i (req_q.b),
    .in_c_i (req_q.c),
    .op_i   (req_q.op),
    .ans_o  (alu_ans)
  );

  // Transaction FSM: accept, execute from latched operands, hold the response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= RR_INIT;
      owner_q  <= 1'b0;
      req_q    <= '{a: 4'h0, b: 4'h0, c: 2'b00, op: OP_SRA};
      result_q <= 4'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_q <= grant;
            req_q   <= sel_req;
            if (FIXED_PRIO == 0) begin
              ptr_q <= ~grant;
            end
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q <= alu_ans;
          state_q  <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_sel) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a round-robin instance for most scenarios
// and a fixed-priority instance for the starvation scenario.
module tb_alu_arbiter;

  typedef struct {
    logic       port;
    logic [3:0] ans;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_c, req0_op, req1_c, req1_op;
  logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [3:0] rsp0_ans, rsp1_ans;
  logic       busy;

  logic       f_req0_valid, f_req1_valid, f_req0_ready, f_req1_ready;
  logic       f_rsp0_valid, f_rsp1_valid, f_busy;
  logic [3:0] f_rsp0_ans, f_rsp1_ans;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_INIT(1'b0), .FIXED_PRIO(0)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_c(req0_c), .req0_op(req0_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_ans(rsp0_ans),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_c(req1_c), .req1_op(req1_op),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_ans(rsp1_ans),
    .busy(busy)
  );

  alu_arbiter #(.RR_INIT(1'b0), .FIXED_PRIO(1)) u_fix (
    .clk(clk), .reset(reset),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(4'd2), .req0_b(4'd3),
    .req0_c(2'd0), .req0_op(2'b11),
    .rsp0_valid(f_rsp0_valid), .rsp0_ready(1'b1), .rsp0_ans(f_rsp0_ans),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(4'd1), .req1_b(4'd1),
    .req1_c(2'd0), .req1_op(2'b11),
    .rsp1_valid(f_rsp1_valid), .rsp1_ready(1'b1), .rsp1_ans(f_rsp1_ans),
    .busy(f_busy)
  );

  function automatic logic [3:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] c, input logic [1:0] op);
    logic [7:0] ext;
    ext = {{4{a[3]}}, a} >> c;
    case (op)
      2'b00:   model = ext[3:0];
      2'b01:   model = a >> c;
      2'b10:   model = a - b;
      default: model = a + b;
    endcase
  endfunction

  // Response monitor: pops the scoreboard on every response handshake
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp0_valid || rsp1_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rsp: got valid0=%b valid1=%b expected none", rsp0_valid, rsp1_valid);
        end
      end
      if (rsp0_valid && rsp1_valid) begin
        failures++;
        $display("FAIL both_rsp_valid: got 11 expected at most one");
      end
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          checks++;
          if (mon_e.port !== rsp1_valid || mon_e.ans !== (rsp1_valid ? rsp1_ans : rsp0_ans)) begin
            failures++;
            $display("FAIL rsp_data: got port=%0d ans=%h expected port=%0d ans=%h",
                     rsp1_valid, rsp1_valid ? rsp1_ans : rsp0_ans, mon_e.port, mon_e.ans);
          end
        end
      end
    end
  end

  // Drives one request on a port (called at a negedge) and waits for its handshake
  task automatic issue(input logic port, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] c, input logic [1:0] op,
                       input logic [3:0] exp_ans, input bit push);
    bit ok = 1'b0;
    if (port) begin
      req1_a = a; req1_b = b; req1_c = c; req1_op = op; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_c = c; req0_op = op; req0_valid = 1'b1;
    end
    for (int i = 0; i < 30 && !ok; i++) begin
      #1;
      if ((port ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        if (push) sb.push_back('{port: port, ans: exp_ans});
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL handshake_timeout: got no ready on port %0d expected ready", port);
    end
    if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout: got busy=%b pending=%0d expected idle and empty", busy, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    req0_a = 4'h0; req0_b = 4'h0; req0_c = 2'd0; req0_op = 2'd0;
    req1_a = 4'h0; req1_b = 4'h0; req1_c = 2'd0; req1_op = 2'd0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, rsp0_valid, rsp1_valid, rsp0_ans, rsp1_ans, req0_ready, req1_ready} !== 13'd0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b v0=%b v1=%b a0=%h a1=%h r0=%b r1=%b expected all 0",
               busy, rsp0_valid, rsp1_valid, rsp0_ans, rsp1_ans, req0_ready, req1_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single_add();
    issue(1'b0, 4'd7, 4'd9, 2'd0, 2'b11, 4'h0, 1'b1);
    #1;
    checks++;
    if (rsp0_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL latency_exec: got v0=%b busy=%b expected v0=0 busy=1", rsp0_valid, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_ans !== 4'h0) begin
      failures++;
      $display("FAIL latency_resp: got v0=%b v1=%b ans=%h expected v0=1 v1=0 ans=0",
               rsp0_valid, rsp1_valid, rsp0_ans);
    end
    wait_idle();
  endtask

  task automatic test_shifts();
    issue(1'b1, 4'b1000, 4'h0, 2'd2, 2'b00, 4'b1110, 1'b1);
    wait_idle();
    issue(1'b1, 4'b1000, 4'h0, 2'd2, 2'b01, 4'b0010, 1'b1);
    wait_idle();
  endtask

  task automatic test_tie_rr();
    logic [3:0] e0, e1;
    for (int r = 0; r < 2; r++) begin
      req0_a = (r == 0) ? 4'd3 : 4'd5; req0_b = (r == 0) ? 4'd5 : 4'd6;
      req0_c = 2'd0; req0_op = (r == 0) ? 2'b10 : 2'b11;
      e0 = (r == 0) ? 4'hE : 4'hB;
      e1 = (r == 0) ? 4'h2 : 4'h7;
      req1_a = (r == 0) ? 4'd1 : 4'hF; req1_b = 4'd1;
      req1_c = (r == 0) ? 2'd0 : 2'd1; req1_op = (r == 0) ? 2'b11 : 2'b01;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL tie_grant_round%0d: got r0=%b r1=%b expected r0=1 r1=0", r, req0_ready, req1_ready);
      end
      if (req0_ready === 1'b1) sb.push_back('{port: 1'b0, ans: e0});
      @(negedge clk);
      req0_valid = 1'b0;
      issue(1'b1, req1_a, req1_b, req1_c, req1_op, e1, 1'b1);
      wait_idle();
    end
  endtask

  task automatic test_fixed_prio();
    int  g0 = 0, g1 = 0;
    bit  ok = 1'b0;
    f_req0_valid = 1'b1; f_req1_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (f_req0_ready === 1'b1) g0++;
      if (f_req1_ready === 1'b1) g1++;
      if (f_rsp0_valid === 1'b1) begin
        checks++;
        if (f_rsp0_ans !== 4'h5) begin
          failures++;
          $display("FAIL fixed_ans0: got %h expected 5", f_rsp0_ans);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (g0 != 4 || g1 != 0) begin
      failures++;
      $display("FAIL fixed_grants: got p0=%0d p1=%0d expected p0=4 p1=0", g0, g1);
    end
    f_req0_valid = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      if (f_req1_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    f_req1_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL fixed_p1_after_release: got no grant expected grant");
    end
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      if (f_rsp1_valid === 1'b1) begin
        ok = 1'b1;
        checks++;
        if (f_rsp1_ans !== 4'h2) begin
          failures++;
          $display("FAIL fixed_ans1: got %h expected 2", f_rsp1_ans);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    rsp0_ready = 1'b0;
    issue(1'b0, 4'd9, 4'd2, 2'd0, 2'b10, 4'd7, 1'b1);
    req1_a = 4'd4; req1_b = 4'd4; req1_c = 2'd0; req1_op = 2'b11; req1_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (rsp0_valid !== 1'b1 || rsp0_ans !== 4'd7 || busy !== 1'b1 || req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: got v0=%b ans=%h busy=%b r1=%b expected 1 7 1 0",
                 i, rsp0_valid, rsp0_ans, busy, req1_ready);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp0_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_during_resp: got %b expected 0", req1_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL resume_accept: got %b expected 1", req1_ready);
    end
    if (req1_ready === 1'b1) sb.push_back('{port: 1'b1, ans: 4'd8});
    @(negedge clk);
    req1_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 4'd1, 4'd2, 2'd0, 2'b11, 4'd3, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_exec: got busy=%b v0=%b v1=%b expected 0 0 0", busy, rsp0_valid, rsp1_valid);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL ptr_after_reset: got r0=%b r1=%b expected r0=1 r1=0", req0_ready, req1_ready);
    end
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL withdrawn_req: got busy=%b expected 0", busy);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic       p;
    logic [3:0] a, b;
    logic [1:0] c, op;
    for (int i = 0; i < 10; i++) begin
      p  = 1'($urandom_range(1, 0));
      a  = 4'($urandom_range(15, 0));
      b  = 4'($urandom_range(15, 0));
      c  = 2'(i % 4);
      op = 2'($urandom_range(3, 0));
      issue(p, a, b, c, op, model(a, b, c, op), 1'b1);
      wait_idle();
    end
  endtask

  initial begin
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_add();
    test_shifts();
    test_tie_rr();
    test_fixed_prio();
    test_backpressure();
    test_reset_mid();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
